// File: rtl/ss_pkg.sv
// rtl/ss_pkg.sv - shared constants and types for the seven-segment scan controller
package ss_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [3:0] AN_OFF    = 4'b1111;

   // Active-low a..g patterns, entry i is digit i
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
      7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
   };

   typedef enum logic {BLANK, DRIVE} scan_state_t;

   typedef struct packed {
      logic [3:0][3:0] digit;
      logic            lz_en;
      logic [3:0]      blink_mask;
      logic            colon;
   } snap_t;

endpackage

// File: rtl/ss_decoder_0_9.sv
// rtl/ss_decoder_0_9.sv - BCD to active-low seven-segment decoder, codes 10-15 blank
module ss_decoder_0_9
   import ss_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (bcd <= 4'd9) seg = SEG_TABLE[bcd];
   end

endmodule

// File: rtl/ss_scan_controller.sv
// rtl/ss_scan_controller.sv - 4-digit multiplexed display scanner with blanking, blink and LZ suppression
module ss_scan_controller
   import ss_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] bcd3,
   input  logic [3:0] bcd2,
   input  logic [3:0] bcd1,
   input  logic [3:0] bcd0,
   input  logic       lz_en,
   input  logic [3:0] blink_mask,
   input  logic       colon,
   output logic [3:0] an,
   output logic [6:0] a_to_g,
   output logic       dp
);

   localparam int SW = $clog2(REFRESH_DIV);
   localparam int FW = $clog2(BLINK_FRAMES + 1);
   localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
   localparam logic [SW-1:0] BLANK_LAST = SW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
   localparam scan_state_t   RESET_STATE = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

   logic [SW-1:0] slot_cnt;
   logic [1:0]    idx;
   logic [FW-1:0] frame_cnt;
   logic          blink_phase;
   logic          slot_wrap;
   snap_t         snap;
   scan_state_t   state, state_next;
   logic [3:0]    digit;
   logic [6:0]    digit_seg;
   logic          suppress;
   logic [3:0]    an_d;
   logic [6:0]    seg_d;
   logic          dp_d;

   assign slot_wrap = (slot_cnt == SLOT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_cnt    <= '0;
         idx         <= 2'd0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (slot_wrap) begin
         slot_cnt <= '0;
         idx      <= idx + 2'd1;
         if (idx == 2'd3) begin
            if (frame_cnt == FRAME_LAST) begin
               frame_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               frame_cnt <= frame_cnt + FW'(1);
            end
         end
      end else begin
         slot_cnt <= slot_cnt + SW'(1);
      end
   end

   // Frame-start snapshot keeps a whole frame consistent against mid-frame input changes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) snap <= '0;
      else if (slot_cnt == '0 && idx == 2'd0)
         snap <= {bcd3, bcd2, bcd1, bcd0, lz_en, blink_mask, colon};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RESET_STATE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         BLANK:   if (slot_cnt == BLANK_LAST) state_next = DRIVE;
         DRIVE:   if (slot_wrap && BLANK_CYCLES > 0) state_next = BLANK;
         default: state_next = RESET_STATE;
      endcase
   end

   assign digit    = snap.digit[idx];
   assign suppress = (idx == 2'd3 && snap.lz_en && digit == 4'd0) ||
                     (snap.blink_mask[idx] && blink_phase);

   ss_decoder_0_9 u_decoder (
      .bcd (digit),
      .seg (digit_seg)
   );

   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (state == DRIVE) begin
         an_d  = ~(4'b0001 << idx);
         seg_d = suppress ? SEG_BLANK : digit_seg;
         dp_d  = ~(idx == 2'd2 && snap.colon);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an     <= AN_OFF;
         a_to_g <= SEG_BLANK;
         dp     <= 1'b1;
      end else begin
         an     <= an_d;
         a_to_g <= seg_d;
         dp     <= dp_d;
      end
   end

endmodule

// File: tb/tb_ss_scan_controller.sv
// tb/tb_ss_scan_controller.sv - self-checking bench for ss_scan_controller
module tb_ss_scan_controller;

   localparam int RD    = 8;
   localparam int BC    = 2;
   localparam int BF    = 2;
   localparam int FRAME = 4 * RD;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] bcd3, bcd2, bcd1, bcd0;
   logic       lz_en;
   logic [3:0] blink_mask;
   logic       colon;
   logic [3:0] an;
   logic [6:0] a_to_g;
   logic       dp;

   int errors = 0;
   int checks = 0;
   int k;
   logic [15:0] m_bcd;
   logic        m_lz, m_col;
   logic [3:0]  m_blink;
   logic [11:0] exp_out;
   logic        chk_en = 1'b0;

   ss_scan_controller #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
      .clk        (clk),
      .rst        (rst),
      .bcd3       (bcd3),
      .bcd2       (bcd2),
      .bcd1       (bcd1),
      .bcd0       (bcd0),
      .lz_en      (lz_en),
      .blink_mask (blink_mask),
      .colon      (colon),
      .an         (an),
      .a_to_g     (a_to_g),
      .dp         (dp)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return 7'b0000001;
         4'd1: return 7'b1001111;
         4'd2: return 7'b0010010;
         4'd3: return 7'b0000110;
         4'd4: return 7'b1001100;
         4'd5: return 7'b0100100;
         4'd6: return 7'b0100000;
         4'd7: return 7'b0001111;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   // Output produced from internal cycle kk (cycles counted from reset release)
   function automatic logic [11:0] model(input int kk, input logic [15:0] b, input logic lz,
                                         input logic [3:0] bm, input logic col);
      int slot, ix;
      logic [3:0] d;
      logic ph, supp;
      slot = kk % RD;
      ix   = (kk / RD) % 4;
      ph   = ((kk / (FRAME * BF)) % 2) == 1;
      if (slot < BC) return 12'hFFF;
      d    = b[ix*4 +: 4];
      supp = (ix == 3 && lz && d == 4'd0) || (bm[ix] && ph);
      return {~(4'b0001 << ix), supp ? 7'b1111111 : seg_of(d), !(ix == 2 && col)};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         k       <= 0;
         m_bcd   <= '0;
         m_lz    <= 1'b0;
         m_blink <= '0;
         m_col   <= 1'b0;
         exp_out <= 12'hFFF;
      end else begin
         exp_out <= model(k, m_bcd, m_lz, m_blink, m_col);
         if (k % FRAME == 0) begin
            m_bcd   <= {bcd3, bcd2, bcd1, bcd0};
            m_lz    <= lz_en;
            m_blink <= blink_mask;
            m_col   <= colon;
         end
         k <= k + 1;
      end
   end

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s cycle=%0d an_seg_dp actual=%b_%b_%b required=%b_%b_%b",
                  name, k, act[11:8], act[7:1], act[0], expv[11:8], expv[7:1], expv[0]);
      end
   endtask

   task automatic lit(input string name, input logic [3:0] an_e, input logic [6:0] seg_e, input logic dp_e);
      check(name, {an, a_to_g, dp}, {an_e, seg_e, dp_e});
   endtask

   task automatic go_to(input int n);
      int guard = 0;
      while (k < n && guard < 4000) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (k < n) begin
         errors++;
         $display("FAIL go_to timeout actual=%0d required=%0d", k, n);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) check("model", {an, a_to_g, dp}, exp_out);
   end

   initial begin
      rst = 1'b1;
      bcd3 = 4'd1; bcd2 = 4'd2; bcd1 = 4'd3; bcd0 = 4'd4;
      lz_en = 1'b0; blink_mask = 4'b0000; colon = 1'b0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      lit("reset_state", 4'b1111, 7'b1111111, 1'b1);
      rst = 1'b0;

      go_to(1);   lit("first_blank0", 4'b1111, 7'b1111111, 1'b1);
      go_to(2);   lit("first_blank1", 4'b1111, 7'b1111111, 1'b1);
      go_to(3);   lit("first_drive",  4'b1110, 7'b1001100, 1'b1);
      go_to(8);   lit("d0_last",      4'b1110, 7'b1001100, 1'b1);
      go_to(9);   lit("slot1_blank",  4'b1111, 7'b1111111, 1'b1);
      go_to(11);  lit("d1_digit3",    4'b1101, 7'b0000110, 1'b1);
      go_to(19);  lit("d2_digit2",    4'b1011, 7'b0010010, 1'b1);
      go_to(27);  lit("d3_digit1",    4'b0111, 7'b1001111, 1'b1);
      go_to(35);  lit("repeat32",     4'b1110, 7'b1001100, 1'b1);

      go_to(50);  bcd0 = 4'd9;
      go_to(67);  lit("snap_next",    4'b1110, 7'b0000100, 1'b1);

      go_to(90);  bcd3 = 4'd0; lz_en = 1'b1;
      go_to(123); lit("lz_on",        4'b0111, 7'b1111111, 1'b1);
      go_to(125); lz_en = 1'b0;
      go_to(150); blink_mask = 4'b0011;
      go_to(155); lit("lz_off",       4'b0111, 7'b0000001, 1'b1);

      go_to(163); lit("blink_vis_d0", 4'b1110, 7'b0000100, 1'b1);
      go_to(171); lit("blink_vis_d1", 4'b1101, 7'b0000110, 1'b1);
      go_to(195); lit("blink_off_d0", 4'b1110, 7'b1111111, 1'b1);
      go_to(203); lit("blink_off_d1", 4'b1101, 7'b1111111, 1'b1);
      go_to(211); lit("blink_keep2",  4'b1011, 7'b0010010, 1'b1);
      go_to(219); lit("blink_keep3",  4'b0111, 7'b0000001, 1'b1);
      go_to(259); lit("blink_back",   4'b1110, 7'b0000100, 1'b1);

      go_to(300); colon = 1'b1; blink_mask = 4'b0000;
      go_to(337); lit("colon_blank",  4'b1111, 7'b1111111, 1'b1);
      go_to(339); lit("colon_dp",     4'b1011, 7'b0010010, 1'b0);
      go_to(347); lit("colon_d3",     4'b0111, 7'b0000001, 1'b1);

      go_to(355); lit("pre_rst",      4'b1110, 7'b0000100, 1'b1);
      #2 rst = 1'b1;
      #1 lit("async_rst", 4'b1111, 7'b1111111, 1'b1);
      bcd2 = 4'd12; colon = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      go_to(3);   lit("rst_d0",       4'b1110, 7'b0000100, 1'b1);
      go_to(19);  lit("illegal_12",   4'b1011, 7'b1111111, 1'b1);
      go_to(27);  lit("rst_d3",       4'b0111, 7'b0000001, 1'b1);
      go_to(40);
      chk_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
